// File: rtl/v_exec_ctrl_pkg.sv
// Shared types and constants for the vector execute controller: VALU opcode
// encodings, vector register geometry, FSM state encoding and default latencies.
package v_exec_ctrl_pkg;

  localparam int ALU_OP_W = 3;
  localparam int LANE_W   = 16;
  localparam int NLANES   = 4;
  localparam int VREG_W   = LANE_W * NLANES;

  localparam logic [ALU_OP_W-1:0] VALU_OP_NOP = 3'd0;
  localparam logic [ALU_OP_W-1:0] VALU_OP_ADD = 3'd1;
  localparam logic [ALU_OP_W-1:0] VALU_OP_MUL = 3'd2;

  localparam int VEXEC_ADD_LAT = 1;
  localparam int VEXEC_MUL_LAT = 3;

  typedef enum logic [1:0] {
    VEXEC_IDLE = 2'd0,
    VEXEC_EXEC = 2'd1,
    VEXEC_WB   = 2'd2
  } vexec_state_t;

endpackage

// File: rtl/v_exec_ctrl_if.sv
// Issue, ALU and writeback signals of the vector execute controller.
// slave = the controller itself, master = the surrounding decode/ALU/regfile.
interface v_exec_ctrl_if
  import v_exec_ctrl_pkg::*;
#(
  parameter int VADDR_W = 5,
  parameter int NVREG   = 32
);

  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [ALU_OP_W-1:0] issue_opcode_i;
  logic [VADDR_W-1:0]  issue_vd_i;
  logic [VREG_W-1:0]   issue_v1_i;
  logic [VREG_W-1:0]   issue_v2_i;

  logic [ALU_OP_W-1:0] alu_opcode_o;
  logic [VREG_W-1:0]   alu_v1_o;
  logic [VREG_W-1:0]   alu_v2_o;
  logic [VREG_W-1:0]   alu_result_i;

  logic                wb_valid_o;
  logic                wb_ready_i;
  logic [VADDR_W-1:0]  wb_vd_o;
  logic [VREG_W-1:0]   wb_data_o;

  logic [NVREG-1:0]    pend_mask_o;
  logic                busy_o;
  logic                illegal_o;

  modport slave (
    input  issue_valid_i, issue_opcode_i, issue_vd_i, issue_v1_i, issue_v2_i,
    input  alu_result_i, wb_ready_i,
    output issue_ready_o, alu_opcode_o, alu_v1_o, alu_v2_o,
    output wb_valid_o, wb_vd_o, wb_data_o, pend_mask_o, busy_o, illegal_o
  );

  modport master (
    output issue_valid_i, issue_opcode_i, issue_vd_i, issue_v1_i, issue_v2_i,
    output alu_result_i, wb_ready_i,
    input  issue_ready_o, alu_opcode_o, alu_v1_o, alu_v2_o,
    input  wb_valid_o, wb_vd_o, wb_data_o, pend_mask_o, busy_o, illegal_o
  );

endinterface

// File: rtl/v_exec_lat_cnt.sv
// Loadable down-counter with a zero flag; times how long ALU inputs are held.
module v_exec_lat_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/v_exec_ctrl.sv
// Single-op issue/sequencing controller in front of the combinational vector ALU:
// holds operands for an opcode-dependent latency, then presents the result for writeback.
module v_exec_ctrl
  import v_exec_ctrl_pkg::*;
#(
  parameter int ADD_LAT = VEXEC_ADD_LAT,
  parameter int MUL_LAT = VEXEC_MUL_LAT,
  parameter int VADDR_W = 5,
  parameter int NVREG   = 32
) (
  input logic          clk,
  input logic          rst,
  v_exec_ctrl_if.slave bus
);

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  vexec_state_t        state;
  logic [ALU_OP_W-1:0] op_r;
  logic [VREG_W-1:0]   v1_r;
  logic [VREG_W-1:0]   v2_r;
  logic [VADDR_W-1:0]  vd_r;
  logic                wb_valid_r;
  logic [VREG_W-1:0]   wb_data_r;
  logic [NVREG-1:0]    pend_r;
  logic                illegal_r;

  logic                ready;
  logic                fire;
  logic                op_valid;
  logic                op_known;
  logic                cnt_zero;
  logic [CNT_W-1:0]    lat_m1;

  assign op_valid = (bus.issue_opcode_i == VALU_OP_ADD) || (bus.issue_opcode_i == VALU_OP_MUL);
  assign op_known = op_valid || (bus.issue_opcode_i == VALU_OP_NOP);
  // Accepting in WB lets a new op overlap the retiring writeback's accept cycle.
  assign ready    = (state == VEXEC_IDLE) || ((state == VEXEC_WB) && bus.wb_ready_i);
  assign fire     = bus.issue_valid_i && ready;
  assign lat_m1   = (bus.issue_opcode_i == VALU_OP_MUL) ? CNT_W'(MUL_LAT - 1)
                                                        : CNT_W'(ADD_LAT - 1);

  v_exec_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (fire && op_valid),
    .dec      ((state == VEXEC_EXEC) && !cnt_zero),
    .load_val (lat_m1),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= VEXEC_IDLE;
      op_r       <= VALU_OP_NOP;
      v1_r       <= '0;
      v2_r       <= '0;
      vd_r       <= '0;
      wb_valid_r <= 1'b0;
      wb_data_r  <= '0;
      pend_r     <= '0;
      illegal_r  <= 1'b0;
    end else begin
      illegal_r <= fire && !op_known;
      case (state)
        VEXEC_EXEC: begin
          if (cnt_zero) begin
            wb_data_r  <= bus.alu_result_i;
            wb_valid_r <= 1'b1;
            op_r       <= VALU_OP_NOP;
            state      <= VEXEC_WB;
          end
        end
        VEXEC_IDLE, VEXEC_WB: begin
          if ((state == VEXEC_WB) && bus.wb_ready_i) begin
            wb_valid_r <= 1'b0;
            pend_r     <= '0;
            state      <= VEXEC_IDLE;
          end
          // Later assignments win: a new op's pending bit overrides the retire clear.
          if (fire) begin
            v1_r <= bus.issue_v1_i;
            v2_r <= bus.issue_v2_i;
            vd_r <= bus.issue_vd_i;
            if (op_valid) begin
              op_r   <= bus.issue_opcode_i;
              pend_r <= {{(NVREG-1){1'b0}}, 1'b1} << bus.issue_vd_i;
              state  <= VEXEC_EXEC;
            end else begin
              op_r <= VALU_OP_NOP;
            end
          end
        end
        default: state <= VEXEC_IDLE;
      endcase
    end
  end

  assign bus.issue_ready_o = ready;
  assign bus.alu_opcode_o  = op_r;
  assign bus.alu_v1_o      = v1_r;
  assign bus.alu_v2_o      = v2_r;
  assign bus.wb_valid_o    = wb_valid_r;
  assign bus.wb_vd_o       = vd_r;
  assign bus.wb_data_o     = wb_data_r;
  assign bus.pend_mask_o   = pend_r;
  assign bus.busy_o        = (state != VEXEC_IDLE);
  assign bus.illegal_o     = illegal_r;

endmodule

// File: tb/tb_v_exec_ctrl.sv
// Bench for v_exec_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_v_exec_ctrl;
  import v_exec_ctrl_pkg::*;

  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 3;
  localparam int VADDR_W = 5;
  localparam int NVREG   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  v_exec_ctrl_if #(.VADDR_W(VADDR_W), .NVREG(NVREG)) bus ();

  v_exec_ctrl #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .VADDR_W (VADDR_W),
    .NVREG   (NVREG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Lane-wise vector ALU (stands in for v_execute), 16-bit wrap per lane.
  function automatic logic [VREG_W-1:0] alu_ref(logic [ALU_OP_W-1:0] op,
                                                logic [VREG_W-1:0] a, logic [VREG_W-1:0] b);
    logic [VREG_W-1:0] r;
    r = '0;
    for (int l = 0; l < NLANES; l++) begin
      if (op == VALU_OP_ADD)      r[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
      else if (op == VALU_OP_MUL) r[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] * b[l*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  always_comb bus.alu_result_i = alu_ref(bus.alu_opcode_o, bus.alu_v1_o, bus.alu_v2_o);

  function automatic logic [VREG_W-1:0] rep(logic [LANE_W-1:0] x);
    return {NLANES{x}};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction-level model: at most one op outstanding, due at fire + LAT + 1.
  bit                  m_busy;
  bit                  m_ill;
  logic [VADDR_W-1:0]  m_vd;
  logic [VREG_W-1:0]   m_data;
  logic [ALU_OP_W-1:0] m_op;
  int                  m_due;
  int                  n_fired;
  int                  n_wb_exp;
  int                  n_retired;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    if (m_busy) n_wb_exp--;
    m_busy = 1'b0;
    m_ill  = 1'b0;
  endtask

  task automatic compare_model();
    bit ev;
    ev = m_busy && (cyc >= m_due);
    chk("wb_valid",    64'(bus.wb_valid_o),    64'(ev));
    chk("busy",        64'(bus.busy_o),        64'(m_busy));
    chk("pend_mask",   64'(bus.pend_mask_o),   m_busy ? (64'd1 << m_vd) : 64'd0);
    chk("pend_onehot", 64'($countones(bus.pend_mask_o) <= 1), 64'd1);
    chk("issue_ready", 64'(bus.issue_ready_o), 64'(!m_busy || (ev && bus.wb_ready_i)));
    chk("illegal",     64'(bus.illegal_o),     64'(m_ill));
    chk("alu_opcode",  64'(bus.alu_opcode_o),  64'((m_busy && !ev) ? m_op : VALU_OP_NOP));
    if (ev) begin
      chk("wb_vd",   64'(bus.wb_vd_o), 64'(m_vd));
      chk("wb_data", bus.wb_data_o,    m_data);
    end
  endtask

  task automatic model_update();
    bit ev, rdy, fire;
    logic [ALU_OP_W-1:0] op;
    ev   = m_busy && (cyc >= m_due);
    rdy  = !m_busy || (ev && bus.wb_ready_i);
    fire = bus.issue_valid_i && rdy;
    op   = bus.issue_opcode_i;
    if (ev && bus.wb_ready_i) begin
      m_busy = 1'b0;
      n_retired++;
    end
    m_ill = fire && (op != VALU_OP_NOP) && (op != VALU_OP_ADD) && (op != VALU_OP_MUL);
    if (fire) n_fired++;
    if (fire && (op == VALU_OP_ADD || op == VALU_OP_MUL)) begin
      m_busy = 1'b1;
      m_op   = op;
      m_vd   = bus.issue_vd_i;
      m_data = alu_ref(op, bus.issue_v1_i, bus.issue_v2_i);
      m_due  = cyc + ((op == VALU_OP_MUL) ? MUL_LAT : ADD_LAT) + 1;
      n_wb_exp++;
    end
  endtask

  task automatic tick();
    #1;
    compare_model();
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(bit v, logic [ALU_OP_W-1:0] op, logic [VADDR_W-1:0] vd,
                       logic [VREG_W-1:0] a, logic [VREG_W-1:0] b, bit rdy);
    bus.issue_valid_i  = v;
    bus.issue_opcode_i = op;
    bus.issue_vd_i     = vd;
    bus.issue_v1_i     = a;
    bus.issue_v2_i     = b;
    bus.wb_ready_i     = rdy;
  endtask

  task automatic drive_idle(bit rdy);
    drive(1'b0, VALU_OP_NOP, '0, '0, '0, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m_busy = 0; m_ill = 0; m_vd = '0; m_data = '0; m_op = '0; m_due = 0;
    n_fired = 0; n_wb_exp = 0; n_retired = 0;
    drive_idle(1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",     64'(bus.busy_o),       64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid_o),   64'd0);
    chk("rst_pend",     64'(bus.pend_mask_o),  64'd0);
    chk("rst_alu_op",   64'(bus.alu_opcode_o), 64'(VALU_OP_NOP));
    chk("rst_alu_v1",   bus.alu_v1_o,          64'd0);
    chk("rst_illegal",  64'(bus.illegal_o),    64'd0);
    @(negedge clk);
    rst = 1'b1;

    // ADD vd=3: 1+2 per lane, result two cycles after issue
    drive(1'b1, VALU_OP_ADD, 5'd3, rep(16'd1), rep(16'd2), 1'b1);
    #1 chk("add_ready_c0", 64'(bus.issue_ready_o), 64'd1);
    tick();
    drive_idle(1'b1);
    #1 chk("add_pend_c1", 64'(bus.pend_mask_o), 64'h8);
    chk("add_novalid_c1", 64'(bus.wb_valid_o), 64'd0);
    tick();
    drive_idle(1'b1);
    #1 chk("add_valid_c2", 64'(bus.wb_valid_o), 64'd1);
    chk("add_vd_c2",   64'(bus.wb_vd_o),     64'd3);
    chk("add_data_c2", bus.wb_data_o,        64'h0003_0003_0003_0003);
    chk("add_pend_c2", 64'(bus.pend_mask_o), 64'h8);
    tick();
    drive_idle(1'b1);
    #1 chk("add_idle_c3", 64'(bus.busy_o), 64'd0);
    tick();

    // MUL vd=7: 5*6 per lane, with writeback backpressure
    drive(1'b1, VALU_OP_MUL, 5'd7, rep(16'd5), rep(16'd6), 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_idle(1'b0);
      #1 chk("mul_exec_ready", 64'(bus.issue_ready_o), 64'd0);
      chk("mul_exec_novalid", 64'(bus.wb_valid_o), 64'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive_idle(1'b0);
      #1 chk("mul_bp_valid", 64'(bus.wb_valid_o), 64'd1);
      chk("mul_bp_data",  bus.wb_data_o,           64'h001E_001E_001E_001E);
      chk("mul_bp_vd",    64'(bus.wb_vd_o),        64'd7);
      chk("mul_bp_ready", 64'(bus.issue_ready_o),  64'd0);
      tick();
    end
    drive_idle(1'b1);
    #1 chk("mul_acc_data", bus.wb_data_o, 64'h001E_001E_001E_001E);
    tick();
    drive_idle(1'b1);
    #1 chk("mul_after_valid", 64'(bus.wb_valid_o), 64'd0);
    tick();

    // Back-to-back to the same vd: pending bit must never drop
    drive(1'b1, VALU_OP_ADD, 5'd1, rep(16'd10), rep(16'd20), 1'b1);
    tick();
    drive_idle(1'b1);
    #1 chk("b2b_pend_c1", 64'(bus.pend_mask_o), 64'h2);
    tick();
    drive(1'b1, VALU_OP_MUL, 5'd1, rep(16'd7), rep(16'd9), 1'b1);
    #1 chk("b2b_add_data", bus.wb_data_o, 64'h001E_001E_001E_001E);
    chk("b2b_ready_wb", 64'(bus.issue_ready_o), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_idle(1'b1);
      #1 chk("b2b_pend_exec", 64'(bus.pend_mask_o), 64'h2);
      tick();
    end
    drive_idle(1'b1);
    #1 chk("b2b_mul_valid", 64'(bus.wb_valid_o), 64'd1);
    chk("b2b_mul_data", bus.wb_data_o, 64'h003F_003F_003F_003F);
    tick();
    drive_idle(1'b1);
    #1 chk("b2b_pend_clear", 64'(bus.pend_mask_o), 64'd0);
    tick();

    // NOP and an out-of-range opcode
    drive(1'b1, VALU_OP_NOP, 5'd4, rep(16'd1), rep(16'd1), 1'b1);
    tick();
    drive_idle(1'b1);
    #1 chk("nop_busy", 64'(bus.busy_o), 64'd0);
    chk("nop_illegal", 64'(bus.illegal_o), 64'd0);
    tick();
    drive(1'b1, 3'd5, 5'd4, rep(16'd1), rep(16'd1), 1'b1);
    tick();
    drive_idle(1'b1);
    #1 chk("ill_pulse", 64'(bus.illegal_o), 64'd1);
    chk("ill_busy", 64'(bus.busy_o), 64'd0);
    tick();
    drive_idle(1'b1);
    #1 chk("ill_pulse_end", 64'(bus.illegal_o), 64'd0);
    tick();

    // Asynchronous reset in the middle of a MUL discards it
    drive(1'b1, VALU_OP_MUL, 5'd9, rep(16'd3), rep(16'd4), 1'b1);
    tick();
    drive_idle(1'b1);
    tick();
    drive_idle(1'b1);
    #1 rst = 1'b0;
    #1 chk("mrst_busy", 64'(bus.busy_o), 64'd0);
    chk("mrst_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("mrst_pend",  64'(bus.pend_mask_o), 64'd0);
    chk("mrst_alu_op", 64'(bus.alu_opcode_o), 64'(VALU_OP_NOP));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_idle(1'b1);
      tick();
    end

    // Randomized traffic
    n_fired = 0;
    for (int budget = 0; budget < 30000 && n_fired < 1000; budget++) begin
      int r;
      logic [ALU_OP_W-1:0] op;
      r = $urandom_range(0, 9);
      if (r == 0)      op = VALU_OP_NOP;
      else if (r == 1) op = ALU_OP_W'($urandom_range(3, 7));
      else if (r < 6)  op = VALU_OP_ADD;
      else             op = VALU_OP_MUL;
      drive(($urandom_range(0, 9) < 7), op, VADDR_W'($urandom_range(0, NVREG - 1)),
            {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      tick();
    end
    chk("rand_ops_issued", 64'(n_fired), 64'd1000);
    for (int i = 0; i < 8; i++) begin
      drive_idle(1'b1);
      tick();
    end
    chk("wb_count", 64'(n_retired), 64'(n_wb_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/v_exec_ctrl.md
Name: v_exec_ctrl

Overview:
- Issue/sequencing controller in front of the combinational vector ALU (v_execute).
- Accepts one vector op at a time over a valid/ready issue port and holds the operands and opcode stable on the ALU inputs for an opcode-dependent number of cycles.
- Captures the ALU result and presents it on a valid/ready writeback port, tagged with the destination vreg index.
- Exports a pending-destination bitmask so decode can stall on RAW hazards.

Parameters:
- ADD_LAT, 1, cycles the ALU inputs are held for VALU_OP_ADD before result capture (>=1).
- MUL_LAT, 3, cycles held for VALU_OP_MUL (>=1); models the multi-cycle multiplier timing budget.
- VADDR_W, 5, vector register index width.
- NVREG, 32, number of vector registers (2**VADDR_W).

Ports:
- clk  in  1  clock.
- rst  in  1  one clock; reset is asynchronous and active-low.
- issue_valid_i  in  1  issue request.
- issue_ready_o  out  1  controller can accept an issue this cycle.
- issue_opcode_i  in  `ALU_OP_BUS  VALU opcode.
- issue_vd_i  in  VADDR_W  destination vreg.
- issue_v1_i  in  `VREG_BUS  operand 1.
- issue_v2_i  in  `VREG_BUS  operand 2.
- alu_opcode_o  out  `ALU_OP_BUS  to ALU.
- alu_v1_o  out  `VREG_BUS  to ALU.
- alu_v2_o  out  `VREG_BUS  to ALU.
- alu_result_i  in  `VREG_BUS  from ALU (combinational).
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  writeback accepted.
- wb_vd_o  out  VADDR_W  writeback destination.
- wb_data_o  out  `VREG_BUS  writeback data.
- pend_mask_o  out  NVREG  bit vd set while an op targeting vd is in EXEC or WB.
- busy_o  out  1  state != IDLE.
- illegal_o  out  1  one-cycle pulse when an issued opcode is not NOP/ADD/MUL.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; all registered outputs 0.
  - alu_opcode_o=VALU_OP_NOP; operand registers 0.
  - wb_valid_o=0, pend_mask_o=0, illegal_o=0, counter 0.
  - A reset asserted mid-EXEC or mid-WB discards the op; no writeback occurs.
- States: IDLE, EXEC, WB.
- Issue handshake:
  - Fire = issue_valid_i && issue_ready_o.
  - issue_ready_o = (state==IDLE) || (state==WB && wb_ready_i). This path is combinational from wb_ready_i.
  - On fire, latch opcode, vd and operands into registers; alu_* outputs are driven only from these registers.
- Fire with ADD/MUL:
  - Next state is EXEC, with cnt = LAT-1 (LAT = ADD_LAT or MUL_LAT).
  - pend_mask_o[vd] set from the next cycle.
- Fire with NOP: accepted, no state change, no writeback; alu_opcode_o returns to NOP.
- Fire with any other opcode: behaves as NOP; illegal_o pulses high for the cycle after fire.
- EXEC:
  - Hold the alu_* outputs; decrement cnt each cycle.
  - When cnt==0, capture alu_result_i into wb_data_o, set wb_valid_o=1, go to WB, and drive alu_opcode_o to NOP.
  - Latency from fire to wb_valid_o is exactly LAT+1 cycles (ADD: 2, MUL: 4 at defaults).
- WB:
  - wb_valid_o, wb_vd_o and wb_data_o stay stable until wb_ready_i is high (AXI-style: no retraction).
  - On accept, clear pend_mask_o[vd]. With no new fire, wb_valid_o=0 and the next state is IDLE.
  - Accept plus simultaneous new fire: the old entry retires; the new op enters EXEC next cycle.
  - If the new vd equals the retiring vd, the bit stays set; set takes priority over clear.
- wb_valid_o is never high outside WB. Only one op is in flight; pend_mask_o has at most one bit set.
- issue_* inputs are ignored when issue_ready_o=0.
- The result width and per-lane wrap-around are the ALU's business. The controller does no arithmetic and passes data bit-exact.

Decomposition:
- Reuse v_defines.v for `ALU_OP_BUS, `VREG_BUS and the VALU_OP_* encodings.
- Add shared constants: VEXEC_IDLE/EXEC/WB state encodings (2 bits) and the default ADD_LAT/MUL_LAT.
- Natural sub-module: v_exec_lat_cnt, a loadable down-counter with a zero flag.
- The v_execute instance stays outside; the top level wires the two blocks together.

Test Plan:
- Reset: rst low mid-MUL (cycle 2 of EXEC), then high -> state IDLE, wb_valid_o=0, pend_mask_o=0, no writeback ever observed.
- ADD:
  - Stimulus: issue at cycle 0 with vd=3, v1 lanes=1, v2 lanes=2, wb_ready_i=1.
  - Response: wb_valid_o high at cycle 2 with all lanes=3 and wb_vd_o=3; pend_mask_o=0x8 during cycles 1-2; IDLE at cycle 3.
- MUL with backpressure:
  - Stimulus: vd=7, lanes 5*6, wb_ready_i=0 for 3 cycles after valid.
  - Response: wb_valid_o rises at cycle 4 and data 30/lane stays stable for 3 cycles; issue_ready_o=0 throughout; accept on the 4th cycle.
- Back-to-back:
  - Stimulus: ADD vd=1, then MUL vd=1 issued in the same cycle the ADD writeback is accepted.
  - Response: both writebacks occur in order; pend_mask_o bit1 stays high continuously.
- NOP and illegal:
  - NOP issue -> no wb_valid_o, busy_o stays 0.
  - Opcode outside NOP/ADD/MUL -> illegal_o one-cycle pulse, no writeback.
- Random: 1000 ops with random wb_ready_i; the scoreboard checks order, data (compared against a v_execute model), and one-hot pend_mask_o.
